// File: rtl/fwd_pkg.sv
// Shared types and widths for the operand forwarding / load-use hazard unit.
package fwd_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } fsm_state_e;

   localparam int unsigned FWD_CNT_W   = 16;
   localparam int unsigned STALL_CNT_W = 8;

endpackage

// File: rtl/fwd_src_mux.sv
// One decode source: finds the youngest matching history entry and either
// forwards its data or reports how many stall cycles it still needs.
module fwd_src_mux
   import fwd_pkg::*;
#(
   parameter int unsigned DATA_W   = 10,
   parameter int unsigned REG_AW   = 3,
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned LOAD_LAT = 1
) (
   input  logic [DEPTH-1:0]        hist_valid_i,
   input  logic [DEPTH-1:0]        hist_load_i,
   input  logic [DEPTH*REG_AW-1:0] hist_addr_i,
   input  logic [DEPTH*DATA_W-1:0] hist_data_i,
   input  logic [REG_AW-1:0]       src_addr_i,
   input  logic                    src_use_i,
   input  logic [DATA_W-1:0]       src_data_i,
   output logic [DATA_W-1:0]       fwd_data_o,
   output logic                    fwd_hit_o,
   output logic                    hazard_o,
   output logic [STALL_CNT_W-1:0]  need_o
);

   logic found;

   always_comb begin
      fwd_data_o = src_data_i;
      fwd_hit_o  = 1'b0;
      hazard_o   = 1'b0;
      need_o     = '0;
      found      = 1'b0;
      // r0 is hardwired zero and never forwarded; only the youngest match counts
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (!found && src_use_i && (src_addr_i != '0) && hist_valid_i[i] &&
             (hist_addr_i[i*REG_AW +: REG_AW] == src_addr_i)) begin
            found = 1'b1;
            if (!hist_load_i[i] || (i >= LOAD_LAT)) begin
               fwd_data_o = hist_data_i[i*DATA_W +: DATA_W];
               fwd_hit_o  = 1'b1;
            end else begin
               hazard_o = 1'b1;
               need_o   = STALL_CNT_W'(LOAD_LAT - i);
            end
         end
      end
   end

endmodule

// File: rtl/forward_hazard_unit.sv
// Write-history based operand forwarding with load-use stall generation
// and a saturating count of forwarding cycles.
module forward_hazard_unit
   import fwd_pkg::*;
#(
   parameter int unsigned DATA_W   = 10,
   parameter int unsigned REG_AW   = 3,
   parameter int unsigned NUM_SRC  = 2,
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned LOAD_LAT = 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      enable,
   input  logic                      flush,
   input  logic                      wr_valid_ex,
   input  logic [REG_AW-1:0]         wr_addr_ex,
   input  logic [DATA_W-1:0]         wr_data_ex,
   input  logic                      wr_is_load_ex,
   input  logic [DATA_W-1:0]         mem_rdata,
   input  logic [NUM_SRC*REG_AW-1:0] src_addr,
   input  logic [NUM_SRC-1:0]        src_use,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   output logic [NUM_SRC*DATA_W-1:0] src_data_fwd,
   output logic [NUM_SRC-1:0]        fwd_hit,
   output logic                      stall,
   output logic [FWD_CNT_W-1:0]      fwd_count
);

   logic [DEPTH-1:0]        valid_q, valid_d;
   logic [DEPTH-1:0]        load_q, load_d;
   logic [DEPTH*REG_AW-1:0] addr_q, addr_d;
   logic [DEPTH*DATA_W-1:0] data_q, data_d;

   fsm_state_e              state_q, state_d;
   logic [STALL_CNT_W-1:0]  cnt_q, cnt_d;
   logic [FWD_CNT_W-1:0]    fwd_cnt_q, fwd_cnt_d;

   logic [NUM_SRC*DATA_W-1:0] mux_data;
   logic [NUM_SRC-1:0]        mux_hit;
   logic [NUM_SRC-1:0]        mux_haz;
   logic [STALL_CNT_W-1:0]    mux_need [NUM_SRC];
   logic                      hazard;
   logic [STALL_CNT_W-1:0]    need_max;
   logic                      stall_c;

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      fwd_src_mux #(
         .DATA_W   (DATA_W),
         .REG_AW   (REG_AW),
         .DEPTH    (DEPTH),
         .LOAD_LAT (LOAD_LAT)
      ) u_mux (
         .hist_valid_i (valid_q),
         .hist_load_i  (load_q),
         .hist_addr_i  (addr_q),
         .hist_data_i  (data_q),
         .src_addr_i   (src_addr[k*REG_AW +: REG_AW]),
         .src_use_i    (src_use[k]),
         .src_data_i   (src_data[k*DATA_W +: DATA_W]),
         .fwd_data_o   (mux_data[k*DATA_W +: DATA_W]),
         .fwd_hit_o    (mux_hit[k]),
         .hazard_o     (mux_haz[k]),
         .need_o       (mux_need[k])
      );
   end

   always_comb begin
      hazard   = |mux_haz;
      need_max = '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         if (mux_haz[k] && (mux_need[k] > need_max)) need_max = mux_need[k];
      end
   end

   assign src_data_fwd = enable ? mux_data : src_data;
   assign fwd_hit      = enable ? mux_hit  : '0;
   assign stall        = stall_c;
   assign fwd_count    = fwd_cnt_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall_c = 1'b0;
      unique case (state_q)
         RUN: begin
            stall_c = hazard;
            if (hazard && (need_max > STALL_CNT_W'(1))) begin
               state_d = STALL;
               cnt_d   = need_max - STALL_CNT_W'(1);
            end
         end
         STALL: begin
            stall_c = 1'b1;
            cnt_d   = cnt_q - STALL_CNT_W'(1);
            if (cnt_q <= STALL_CNT_W'(1)) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase
      if (!enable || flush) begin
         stall_c = 1'b0;
         state_d = RUN;
         cnt_d   = '0;
      end
   end

   // Stalled cycles push a bubble into entry 0; load data is swapped in as the
   // entry crosses from LOAD_LAT-1 to LOAD_LAT.
   always_comb begin
      valid_d = '0;
      load_d  = '0;
      addr_d  = '0;
      data_d  = '0;
      if (!flush) begin
         if (!stall_c) begin
            valid_d[0]          = wr_valid_ex;
            load_d[0]           = wr_is_load_ex;
            addr_d[REG_AW-1:0]  = wr_addr_ex;
            data_d[DATA_W-1:0]  = wr_data_ex;
         end
         for (int unsigned i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            load_d[i]  = load_q[i-1];
            addr_d[i*REG_AW +: REG_AW] = addr_q[(i-1)*REG_AW +: REG_AW];
            if ((i == LOAD_LAT) && load_q[i-1]) data_d[i*DATA_W +: DATA_W] = mem_rdata;
            else data_d[i*DATA_W +: DATA_W] = data_q[(i-1)*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      fwd_cnt_d = fwd_cnt_q;
      if ((|fwd_hit) && (fwd_cnt_q != '1)) fwd_cnt_d = fwd_cnt_q + FWD_CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q   <= '0;
         load_q    <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         state_q   <= RUN;
         cnt_q     <= '0;
         fwd_cnt_q <= '0;
      end else begin
         valid_q   <= valid_d;
         load_q    <= load_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         fwd_cnt_q <= fwd_cnt_d;
      end
   end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench: DUT A uses default geometry, DUT B uses DEPTH=3/LOAD_LAT=2.
module tb_forward_hazard_unit;

   localparam int unsigned DW = 10;
   localparam int unsigned AW = 3;
   localparam int unsigned NS = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset_n, enable, flush;
   logic             wr_valid_ex, wr_is_load_ex;
   logic [AW-1:0]    wr_addr_ex;
   logic [DW-1:0]    wr_data_ex, mem_rdata;
   logic [NS*AW-1:0] src_addr;
   logic [NS-1:0]    src_use;
   logic [NS*DW-1:0] src_data;

   logic [NS*DW-1:0] fwd_a, fwd_b;
   logic [NS-1:0]    hit_a, hit_b;
   logic             stall_a, stall_b;
   logic [15:0]      cnt_a, cnt_b;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   forward_hazard_unit #(
      .DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS), .DEPTH(2), .LOAD_LAT(1)
   ) dut_a (
      .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
      .wr_valid_ex(wr_valid_ex), .wr_addr_ex(wr_addr_ex), .wr_data_ex(wr_data_ex),
      .wr_is_load_ex(wr_is_load_ex), .mem_rdata(mem_rdata),
      .src_addr(src_addr), .src_use(src_use), .src_data(src_data),
      .src_data_fwd(fwd_a), .fwd_hit(hit_a), .stall(stall_a), .fwd_count(cnt_a)
   );

   forward_hazard_unit #(
      .DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS), .DEPTH(3), .LOAD_LAT(2)
   ) dut_b (
      .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
      .wr_valid_ex(wr_valid_ex), .wr_addr_ex(wr_addr_ex), .wr_data_ex(wr_data_ex),
      .wr_is_load_ex(wr_is_load_ex), .mem_rdata(mem_rdata),
      .src_addr(src_addr), .src_use(src_use), .src_data(src_data),
      .src_data_fwd(fwd_b), .fwd_hit(hit_b), .stall(stall_b), .fwd_count(cnt_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic ld);
      wr_valid_ex   = 1'b1;
      wr_addr_ex    = a;
      wr_data_ex    = d;
      wr_is_load_ex = ld;
   endtask

   task automatic no_wr();
      wr_valid_ex   = 1'b0;
      wr_addr_ex    = '0;
      wr_data_ex    = '0;
      wr_is_load_ex = 1'b0;
   endtask

   task automatic do_flush();
      flush   = 1'b1;
      enable  = 1'b1;
      src_use = '0;
      no_wr();
      tick();
      flush = 1'b0;
   endtask

   initial begin
      reset_n   = 1'b0;
      enable    = 1'b1;
      flush     = 1'b0;
      mem_rdata = '0;
      no_wr();
      src_addr = {3'd1, 3'd1};
      src_use  = 2'b11;
      src_data = {10'h3AA, 10'h155};
      #2;
      chk("rst_stall_a", 32'(stall_a), 0);
      chk("rst_hit_a",   32'(hit_a), 0);
      chk("rst_fwd_a",   32'(fwd_a), 32'({10'h3AA, 10'h155}));
      chk("rst_cnt_a",   32'(cnt_a), 0);
      chk("rst_stall_b", 32'(stall_b), 0);
      tick();
      tick();
      reset_n = 1'b1;
      src_use = '0;
      tick();

      // single ALU forward from entry 0
      wr(3'd1, 10'h008, 1'b0);
      tick();
      no_wr();
      src_addr = {3'd0, 3'd1};
      src_use  = 2'b01;
      src_data = {10'h0AA, 10'h0BB};
      #1;
      chk("fwd1_data_a", 32'(fwd_a), 32'({10'h0AA, 10'h008}));
      chk("fwd1_hit_a",  32'(hit_a), 32'(2'b01));
      chk("fwd1_stall_a", 32'(stall_a), 0);
      chk("fwd1_data_b", 32'(fwd_b), 32'({10'h0AA, 10'h008}));
      tick();
      src_use = '0;
      chk("fwd1_cnt_a", 32'(cnt_a), 1);

      // youngest of two writes to r3 wins; older one ages out of DUT A
      do_flush();
      wr(3'd3, 10'h022, 1'b0);
      tick();
      wr(3'd3, 10'h011, 1'b0);
      tick();
      no_wr();
      src_addr = {3'd3, 3'd0};
      src_use  = 2'b10;
      src_data = {10'h1F0, 10'h0F1};
      #1;
      chk("young_data_a", 32'(fwd_a), 32'({10'h011, 10'h0F1}));
      chk("young_hit_a",  32'(hit_a), 32'(2'b10));
      chk("young_data_b", 32'(fwd_b), 32'({10'h011, 10'h0F1}));
      tick();
      chk("aged_data_a", 32'(fwd_a), 32'({10'h011, 10'h0F1}));
      chk("aged_data_b", 32'(fwd_b), 32'({10'h011, 10'h0F1}));
      tick();
      src_use = '0;
      chk("young_cnt_a", 32'(cnt_a), 3);

      // load-use: A stalls once, B stalls twice
      do_flush();
      wr(3'd2, 10'h3FF, 1'b1);
      tick();
      no_wr();
      src_addr  = {3'd0, 3'd2};
      src_use   = 2'b01;
      src_data  = {10'h000, 10'h0C0};
      mem_rdata = 10'h155;
      #1;
      chk("lu_c1_stall_a", 32'(stall_a), 1);
      chk("lu_c1_hit_a",   32'(hit_a), 0);
      chk("lu_c1_fwd_a",   32'(fwd_a), 32'({10'h000, 10'h0C0}));
      chk("lu_c1_stall_b", 32'(stall_b), 1);
      tick();
      mem_rdata = 10'h2C3;
      #1;
      chk("lu_c2_stall_a", 32'(stall_a), 0);
      chk("lu_c2_hit_a",   32'(hit_a), 32'(2'b01));
      chk("lu_c2_fwd_a",   32'(fwd_a), 32'({10'h000, 10'h155}));
      chk("lu_c2_stall_b", 32'(stall_b), 1);
      chk("lu_c2_hit_b",   32'(hit_b), 0);
      tick();
      mem_rdata = '0;
      #1;
      chk("lu_c3_stall_b", 32'(stall_b), 0);
      chk("lu_c3_hit_b",   32'(hit_b), 32'(2'b01));
      chk("lu_c3_fwd_b",   32'(fwd_b), 32'({10'h000, 10'h2C3}));

      // r0 destination and unused sources never forward or stall
      do_flush();
      wr(3'd5, 10'h111, 1'b1);
      tick();
      wr(3'd0, 10'h0FF, 1'b1);
      tick();
      no_wr();
      src_addr = {3'd5, 3'd0};
      src_use  = 2'b01;
      src_data = {10'h2AA, 10'h255};
      #1;
      chk("r0_stall_a", 32'(stall_a), 0);
      chk("r0_hit_a",   32'(hit_a), 0);
      chk("r0_fwd_a",   32'(fwd_a), 32'({10'h2AA, 10'h255}));
      chk("r0_stall_b", 32'(stall_b), 0);
      chk("r0_hit_b",   32'(hit_b), 0);

      // flush while B is in its second stall cycle
      do_flush();
      wr(3'd4, 10'h0AB, 1'b1);
      tick();
      no_wr();
      src_addr = {3'd0, 3'd4};
      src_use  = 2'b01;
      #1;
      chk("fl_pre_stall_b", 32'(stall_b), 1);
      tick();
      flush = 1'b1;
      #1;
      chk("fl_cyc_stall_b", 32'(stall_b), 0);
      tick();
      flush = 1'b0;
      #1;
      chk("fl_post_stall_b", 32'(stall_b), 0);
      chk("fl_post_hit_b",   32'(hit_b), 0);
      chk("fl_post_hit_a",   32'(hit_a), 0);

      // disabled: pass-through, but history keeps moving
      do_flush();
      wr(3'd7, 10'h033, 1'b1);
      tick();
      no_wr();
      src_addr  = {3'd0, 3'd7};
      src_use   = 2'b01;
      src_data  = {10'h2AA, 10'h255};
      mem_rdata = 10'h0C7;
      enable    = 1'b0;
      #1;
      chk("dis_stall_a", 32'(stall_a), 0);
      chk("dis_hit_a",   32'(hit_a), 0);
      chk("dis_fwd_a",   32'(fwd_a), 32'({10'h2AA, 10'h255}));
      chk("dis_stall_b", 32'(stall_b), 0);
      tick();
      enable    = 1'b1;
      mem_rdata = '0;
      #1;
      chk("reen_hit_a",   32'(hit_a), 32'(2'b01));
      chk("reen_fwd_a",   32'(fwd_a), 32'({10'h2AA, 10'h0C7}));
      chk("reen_stall_a", 32'(stall_a), 0);
      chk("reen_stall_b", 32'(stall_b), 1);

      // asynchronous reset in the middle of B's stall
      do_flush();
      wr(3'd6, 10'h044, 1'b1);
      tick();
      no_wr();
      src_addr = {3'd0, 3'd6};
      src_use  = 2'b01;
      src_data = {10'h100, 10'h200};
      tick();
      #1;
      chk("rs_pre_stall_b", 32'(stall_b), 1);
      chk("rs_pre_hit_a",   32'(hit_a), 32'(2'b01));
      reset_n = 1'b0;
      #1;
      chk("rs_stall_b", 32'(stall_b), 0);
      chk("rs_hit_a",   32'(hit_a), 0);
      chk("rs_cnt_a",   32'(cnt_a), 0);
      chk("rs_cnt_b",   32'(cnt_b), 0);
      chk("rs_fwd_a",   32'(fwd_a), 32'({10'h100, 10'h200}));
      tick();
      reset_n = 1'b1;
      #1;
      chk("rs_rel_stall_b", 32'(stall_b), 0);
      chk("rs_rel_stall_a", 32'(stall_a), 0);

      // counter saturation under a continuous forwarding stream
      wr(3'd1, 10'h155, 1'b0);
      src_addr = {3'd0, 3'd1};
      src_use  = 2'b01;
      tick();
      chk("sat_start_a", 32'(cnt_a), 0);
      repeat (65534) @(posedge clk);
      #1;
      chk("sat_fffe_a", 32'(cnt_a), 32'h0000_FFFE);
      tick();
      chk("sat_ffff_a", 32'(cnt_a), 32'h0000_FFFF);
      repeat (4) @(posedge clk);
      #1;
      chk("sat_hold_a", 32'(cnt_a), 32'h0000_FFFF);
      chk("sat_hold_b", 32'(cnt_b), 32'h0000_FFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
